// File: rtl/conv_fprop2_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier among NUM_REQ requesters.
// Response backpressure freezes the multiplier and the valid/ID tracking pipeline through mul_ce.
module conv_fprop2_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int DIN_WIDTH   = 31,
    parameter int DOUT_WIDTH  = 62,
    parameter int MUL_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DOUT_WIDTH-1:0]          rsp_data,
    output logic                           mul_ce,
    output logic [DIN_WIDTH-1:0]           mul_din0,
    output logic [DIN_WIDTH-1:0]           mul_din1,
    input  logic [DOUT_WIDTH-1:0]          mul_dout,
    output logic                           idle
);

    logic [ID_WIDTH-1:0]    rr_ptr;
    logic                   grant_vld;
    logic [ID_WIDTH-1:0]    grant_id;
    logic                   xfer;
    logic [MUL_LATENCY-1:0] vld_p;
    logic [ID_WIDTH-1:0]    id_p [MUL_LATENCY];

    // Walk offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        int                  idx;
        logic [ID_WIDTH-1:0] idx_w;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx   = (int'(rr_ptr) + k) % NUM_REQ;
            idx_w = ID_WIDTH'(idx);
            if (req_valid[idx_w]) begin
                grant_vld = 1'b1;
                grant_id  = idx_w;
            end
        end
    end

    assign mul_ce = !reset && (!rsp_valid || rsp_ready);
    assign xfer   = grant_vld && mul_ce;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign mul_din0 = grant_vld ? req_a[grant_id*DIN_WIDTH +: DIN_WIDTH] : '0;
    assign mul_din1 = grant_vld ? req_b[grant_id*DIN_WIDTH +: DIN_WIDTH] : '0;

    // Stage 0 .. MUL_LATENCY-1: valid/ID shadow of the multiplier pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            vld_p  <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                id_p[i] <= '0;
            end
        end else if (mul_ce) begin
            vld_p[0] <= xfer;
            id_p[0]  <= grant_id;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                id_p[i]  <= id_p[i-1];
            end
            if (xfer) begin
                rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    assign rsp_valid = vld_p[MUL_LATENCY-1];
    assign rsp_id    = id_p[MUL_LATENCY-1];
    assign rsp_data  = mul_dout;
    assign idle      = !(|vld_p) && !(|req_valid);

endmodule

// File: tb/tb_conv_fprop2_mul_arbiter.sv
// Bench for conv_fprop2_mul_arbiter: directed tests on a latency-1 instance and random
// traffic with random backpressure on a latency-3 instance, checked by a per-requester scoreboard.
module tb_conv_fprop2_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 31;
    localparam int OW   = 62;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return DW'($urandom);
        endcase
    endfunction

    logic            rst      [2];
    logic [NREQ-1:0] req_vld  [2];
    logic [NREQ-1:0] req_rdy  [2];
    logic [DW-1:0]   opa      [2][NREQ];
    logic [DW-1:0]   opb      [2][NREQ];
    logic            rsp_vld  [2];
    logic            rsp_rdy  [2];
    logic [IDW-1:0]  rsp_idx  [2];
    logic [OW-1:0]   rsp_dat  [2];
    logic            ce       [2];
    logic [DW-1:0]   din0     [2];
    logic [DW-1:0]   din1     [2];
    logic            idle_o   [2];
    int              pend     [2];

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [NREQ*DW-1:0] a_bus, b_bus;
        logic [OW-1:0]      dout;
        logic [OW-1:0]      pipe [LAT];
        logic [OW-1:0]      sbq  [NREQ][$];
        int                 oq   [$];
        int                 id;

        always_comb begin
            a_bus = '0;
            b_bus = '0;
            for (int r = 0; r < NREQ; r++) begin
                a_bus[r*DW +: DW] = opa[k][r];
                b_bus[r*DW +: DW] = opb[k][r];
            end
        end

        conv_fprop2_mul_arbiter #(
            .NUM_REQ(NREQ), .ID_WIDTH(IDW), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MUL_LATENCY(LAT)
        ) dut (
            .clk(clk), .reset(rst[k]),
            .req_valid(req_vld[k]), .req_ready(req_rdy[k]),
            .req_a(a_bus), .req_b(b_bus),
            .rsp_valid(rsp_vld[k]), .rsp_ready(rsp_rdy[k]),
            .rsp_id(rsp_idx[k]), .rsp_data(rsp_dat[k]),
            .mul_ce(ce[k]), .mul_din0(din0[k]), .mul_din1(din1[k]), .mul_dout(dout),
            .idle(idle_o[k])
        );

        // Multiplier model: LAT registers advancing only on ce.
        always @(posedge clk) begin
            if (ce[k]) begin
                pipe[0] <= OW'(din0[k]) * OW'(din1[k]);
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign dout = pipe[LAT-1];

        // Scoreboard: responses retire in issue order; products kept per requester.
        always @(negedge clk) begin
            if (rst[k]) begin
                oq.delete();
                for (int r = 0; r < NREQ; r++) sbq[r].delete();
                pend[k] = 0;
            end else begin
                if (rsp_vld[k] && rsp_rdy[k]) begin
                    if (oq.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_idx[k]), 64'hFFFF);
                    end else begin
                        id = oq.pop_front();
                        pend[k]--;
                        chk("sb_rsp_id", 64'(rsp_idx[k]), 64'(id));
                        chk("sb_rsp_data", 64'(rsp_dat[k]), 64'(sbq[id].pop_front()));
                    end
                end
                for (int r = 0; r < NREQ; r++) begin
                    if (req_vld[k][r] && req_rdy[k][r]) begin
                        oq.push_back(r);
                        sbq[r].push_back(OW'(opa[k][r]) * OW'(opb[k][r]));
                        pend[k]++;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset0();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
    endtask

    // All four requesters stay valid; grants must rotate, granted operands are refreshed.
    task automatic run_all(input int n, input int start);
        logic [NREQ-1:0] g;
        for (int i = start; i < start + n; i++) begin
            @(negedge clk);
            g = req_rdy[0];
            chk("rr_grant", 64'(g), 64'(4'b0001 << (i % 4)));
            step();
            for (int r = 0; r < NREQ; r++) begin
                if (g[r]) begin
                    opa[0][r] = rnd();
                    opb[0][r] = rnd();
                end
            end
        end
    endtask

    initial begin
        logic [OW-1:0]   hd;
        logic [IDW-1:0]  hi;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] fair_exp [3];
        int              w;

        for (int k = 0; k < 2; k++) begin
            rst[k]     = 1'b1;
            req_vld[k] = '0;
            rsp_rdy[k] = 1'b1;
            for (int r = 0; r < NREQ; r++) begin
                opa[k][r] = '0;
                opb[k][r] = '0;
            end
        end
        step();
        step();
        @(negedge clk);
        chk("reset_ready", 64'(req_rdy[0]), 64'd0);
        chk("reset_ce", 64'(ce[0]), 64'd0);
        chk("reset_rsp_vld", 64'(rsp_vld[0]), 64'd0);
        chk("reset_rsp_id", 64'(rsp_idx[0]), 64'd0);
        chk("reset_idle", 64'(idle_o[0]), 64'd1);
        chk("reset_din0", 64'(din0[0]), 64'd0);
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single request from requester 2 with maximum operands.
        opa[0][2]  = 31'h7FFFFFFF;
        opb[0][2]  = 31'h7FFFFFFF;
        req_vld[0] = 4'b0100;
        @(negedge clk);
        chk("single_ready", 64'(req_rdy[0]), 64'b0100);
        chk("single_din0", 64'(din0[0]), 64'h7FFFFFFF);
        chk("single_idle", 64'(idle_o[0]), 64'd0);
        step();
        req_vld[0] = '0;
        @(negedge clk);
        chk("single_vld", 64'(rsp_vld[0]), 64'd1);
        chk("single_id", 64'(rsp_idx[0]), 64'd2);
        chk("single_data", 64'(rsp_dat[0]), 64'h3FFFFFFF00000001);
        step();
        @(negedge clk);
        chk("single_vld_off", 64'(rsp_vld[0]), 64'd0);
        step();

        // One operation in flight, held by rsp_ready=0, then reset.
        opa[0][1]  = 31'd5;
        opb[0][1]  = 31'd7;
        req_vld[0] = 4'b0010;
        @(negedge clk);
        chk("inflight_ready", 64'(req_rdy[0]), 64'b0010);
        step();
        req_vld[0] = '0;
        rsp_rdy[0] = 1'b0;
        @(negedge clk);
        chk("inflight_vld", 64'(rsp_vld[0]), 64'd1);
        chk("inflight_ce", 64'(ce[0]), 64'd0);
        step();
        rst[0] = 1'b1;
        @(negedge clk);
        chk("reset_mid_ce", 64'(ce[0]), 64'd0);
        step();
        rst[0]     = 1'b0;
        rsp_rdy[0] = 1'b1;
        opa[0][0]  = 31'd2;
        opb[0][0]  = 31'd3;
        opa[0][2]  = 31'd4;
        opb[0][2]  = 31'd9;
        req_vld[0] = 4'b0101;
        @(negedge clk);
        chk("post_reset_vld", 64'(rsp_vld[0]), 64'd0);
        chk("post_reset_ptr", 64'(req_rdy[0]), 64'b0001);
        step();
        req_vld[0] = 4'b0100;
        @(negedge clk);
        chk("post_reset_data", 64'(rsp_dat[0]), 64'd6);
        chk("post_reset_id", 64'(rsp_idx[0]), 64'd0);
        chk("post_reset_next", 64'(req_rdy[0]), 64'b0100);
        step();
        req_vld[0] = '0;
        @(negedge clk);
        chk("post_reset_data2", 64'(rsp_dat[0]), 64'd36);
        step();
        step();
        pulse_reset0();

        // Continuous traffic from all four, then three cycles of backpressure.
        for (int r = 0; r < NREQ; r++) begin
            opa[0][r] = rnd();
            opb[0][r] = rnd();
        end
        req_vld[0] = 4'b1111;
        run_all(12, 0);
        rsp_rdy[0] = 1'b0;
        hd = rsp_dat[0];
        hi = rsp_idx[0];
        chk("bp_vld", 64'(rsp_vld[0]), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ce", 64'(ce[0]), 64'd0);
            chk("bp_ready", 64'(req_rdy[0]), 64'd0);
            chk("bp_data", 64'(rsp_dat[0]), 64'(hd));
            chk("bp_id", 64'(rsp_idx[0]), 64'(hi));
            step();
        end
        rsp_rdy[0] = 1'b1;
        run_all(8, 12);
        req_vld[0] = '0;
        repeat (3) step();

        // Fairness: rr_ptr brought to 2, then requesters 1 and 3 compete.
        pulse_reset0();
        opa[0][1]  = rnd();
        opb[0][1]  = rnd();
        req_vld[0] = 4'b0010;
        @(negedge clk);
        chk("fair_setup", 64'(req_rdy[0]), 64'b0010);
        step();
        opa[0][1]  = rnd();
        opb[0][1]  = rnd();
        opa[0][3]  = rnd();
        opb[0][3]  = rnd();
        req_vld[0] = 4'b1010;
        fair_exp[0] = 4'b1000;
        fair_exp[1] = 4'b0010;
        fair_exp[2] = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            g = req_rdy[0];
            chk("fair_grant", 64'(g), 64'(fair_exp[i]));
            step();
            for (int r = 0; r < NREQ; r++) begin
                if (g[r]) begin
                    opa[0][r] = rnd();
                    opb[0][r] = rnd();
                end
            end
        end
        req_vld[0] = '0;
        repeat (3) step();
        @(negedge clk);
        chk("inst0_idle", 64'(idle_o[0]), 64'd1);
        chk("inst0_pending", 64'(pend[0]), 64'd0);

        // Random traffic and random rsp_ready on the latency-3 instance.
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            g = req_vld[1] & req_rdy[1];
            step();
            for (int r = 0; r < NREQ; r++) begin
                if (g[r] || !req_vld[1][r]) begin
                    req_vld[1][r] = ($urandom_range(0, 2) != 0);
                    opa[1][r]     = rnd();
                    opb[1][r]     = rnd();
                end
            end
            rsp_rdy[1] = ($urandom_range(0, 3) != 0);
        end
        req_vld[1] = '0;
        rsp_rdy[1] = 1'b1;
        w = 0;
        while (!idle_o[1] && w < 100) begin
            step();
            w++;
        end
        @(negedge clk);
        chk("rand_drain_idle", 64'(idle_o[1]), 64'd1);
        chk("rand_pending", 64'(pend[1]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/conv_fprop2_mul_arbiter.md
# conv_fprop2_mul_arbiter

Round-robin arbiter that shares one pipelined unsigned 31x31->62 multiplier among `NUM_REQ` requesters in the conv_fprop2 datapath. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `ce`/`din0`/`din1`. It tracks in-flight operations with a latency-matched valid/ID pipeline and returns each product on a single tagged response port with backpressure. Stalling the response port freezes the whole multiplier pipeline through `ce`.

## Interface
- `NUM_REQ`, 4, number of requesters, 2..8
- `ID_WIDTH`, 2, width of requester ID, = clog2(`NUM_REQ`)
- `DIN_WIDTH`, 31, operand width (unsigned)
- `DOUT_WIDTH`, 62, product width
- `MUL_LATENCY`, 1, cycles with `ce`=1 from operands on `din0`/`din1` to product on `dout`, 1..4

Ports:
- `clk`  in  1  single clock; all state on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high
- `req_a`  in  NUM_REQ*DIN_WIDTH  packed operand A; requester i is bits [i*DIN_WIDTH +: DIN_WIDTH]
- `req_b`  in  NUM_REQ*DIN_WIDTH  packed operand B; same packing as `req_a`
- `rsp_valid`  out  1  product available
- `rsp_ready`  in  1  consumer accepts product
- `rsp_id`  out  ID_WIDTH  index of the requester that issued the product
- `rsp_data`  out  DOUT_WIDTH  product, wired directly from `mul_dout`
- `mul_ce`  out  1  multiplier clock enable
- `mul_din0`  out  DIN_WIDTH  multiplier operand A
- `mul_din1`  out  DIN_WIDTH  multiplier operand B
- `mul_dout`  in  DOUT_WIDTH  multiplier product
- `idle`  out  1  no valid entry in the pipeline and no `req_valid` bit set

## Operation
- Round-robin pointer `rr_ptr` (ID_WIDTH bits), reset to 0.
- Grant (combinational): the first i with `req_valid[i]`=1, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`. No valid bit means no grant.
- `mul_ce` = !`reset` && (!`rsp_valid` || `rsp_ready`).
- `req_ready[i]` = `mul_ce` && grant==i. A transfer is `req_valid[i]` && `req_ready[i]`.
- On a transfer from requester g:
  - `mul_din0`/`mul_din1` are `req_a`/`req_b` slice g.
  - `rr_ptr` <= (g+1) mod `NUM_REQ`.
- With no grant, `mul_din0`/`mul_din1` are 0 and `rr_ptr` holds.
- Tracking pipeline of `MUL_LATENCY` stages, each holding {vld, id}:
  - Advances only when `mul_ce`=1.
  - Stage 0 loads {transfer, g}. A bubble loads vld=0.
  - `rsp_valid`/`rsp_id` come from the last stage.
- Response completes on `rsp_valid` && `rsp_ready`. When `rsp_ready`=0 with `rsp_valid`=1:
  - `mul_ce`=0, so the multiplier and tracking pipeline freeze.
  - `rsp_data`/`rsp_id` stay stable.
  - No new requests are granted.
- Bubbles in the pipeline drain whenever `rsp_valid`=0, even if `rsp_ready`=0.
- Product equals `req_a`*`req_b` as unsigned values, with no truncation: 31+31=62 bits.
- `idle` = no stage vld && `req_valid`==0.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, every stage vld=0 and id=0, `rr_ptr`=0.
  - `req_ready`=0 and `mul_ce`=0 while `reset`=1.
  - `idle`=1 when `req_valid`=0.
- Latency: a transfer at edge t puts the product on `rsp_valid`/`rsp_data` after edge t+`MUL_LATENCY`, provided no stall intervenes. Each stall cycle adds one cycle.
- Throughput: one product per cycle while `rsp_ready`=1 and requests are present.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester holds `req_valid` and its operands until its transfer.
- Reset mid-operation:
  - All in-flight entries are dropped with no response.
  - `mul_dout` contents are ignored because every vld is cleared.
- Transfer and response in the same cycle are legal and required for full throughput.
- With a single persistent requester, it is granted every cycle.
- Pointer wrap: a grant to `NUM_REQ`-1 sets `rr_ptr` to 0.

## Test plan
- Single request, `MUL_LATENCY`=1:
  - Stimulus: requester 2 sends a=0x7FFFFFFF, b=0x7FFFFFFF; `rsp_ready`=1.
  - Required: `rsp_valid` is high exactly one cycle after the transfer, `rsp_id`=2, `rsp_data`=0x3FFFFFFF00000001.
- All four requesters valid continuously, `rsp_ready`=1:
  - Required: grants follow 0,1,2,3,0,...; one response per cycle; each `rsp_id` matches its issue order; each product is correct.
- Backpressure:
  - Stimulus: drive `rsp_ready`=0 for 3 cycles while `rsp_valid`=1.
  - Required: `mul_ce`=0, all `req_ready`=0, `rsp_data`/`rsp_id` stable; on release, results continue in order with no loss or duplication.
- Fairness:
  - Stimulus: requesters 1 and 3 valid; `rr_ptr`=2.
  - Required: grants go 3, then 1, then 3.
- Reset with 1 in flight:
  - Stimulus: assert `reset` for one cycle while one operation is in flight.
  - Required: no `rsp_valid` afterward; `rr_ptr`=0; the next request from requester 0 completes normally with product 6 for a=2, b=3.
- Random traffic and random `rsp_ready`, `MUL_LATENCY`=3:
  - Required: every accepted request yields exactly one response; products match a scoreboard keyed by requester in FIFO order.
